// File: rtl/cache_data_array_bank.sv
// Multi-way cache data bank with byte-masked writes, registered reads
// and a hardware sweep that zeroes every line after reset or on request.
module cache_data_array_bank #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 128,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned BYTES = DATA_W / 8
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WAY_W-1:0]  req_way,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [BYTES-1:0]  req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [WAY_W:0] WAYS_C   = (WAY_W+1)'(WAYS);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] mem_q [WAYS][DEPTH];

  logic              st_idle, st_clear;
  logic              acc, way_ok;
  logic              wr_en, clr_en;
  logic [DATA_W-1:0] cur_line;
  logic [DATA_W-1:0] wr_line;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_clear   = (state_q == ST_CLEAR);
  assign req_ready  = st_idle;
  assign clear_busy = st_clear;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

  assign acc    = req_valid && req_ready;
  assign way_ok = ({1'b0, req_way} < WAYS_C);
  assign wr_en  = acc && req_write && way_ok && !RST;
  assign clr_en = st_clear && !RST;

  // Addressed line and its byte-merged replacement
  always_comb begin
    cur_line = '0;
    if (way_ok) cur_line = mem_q[req_way][req_index];
    wr_line = cur_line;
    for (int i = 0; i < BYTES; i++) begin
      if (req_wstrb[i]) wr_line[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // Sweep sequencing; reset always restarts the sweep from line 0
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (1'b1)
      st_idle: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      st_clear: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_C) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
    if (RST) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end
  end

  // Read response; data only moves on an accepted read
  always_comb begin
    rsp_valid_d = acc && !req_write;
    rsp_rdata_d = rsp_rdata_q;
    if (acc && !req_write) rsp_rdata_d = cur_line;
    if (RST) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
    end
  end

  // Control and response registers
  always_ff @(posedge CK) begin
    state_q     <= state_d;
    clr_idx_q   <= clr_idx_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_rdata_q <= rsp_rdata_d;
  end

  // Storage: sweep zeroes one line of every way, else masked write
  always_ff @(posedge CK) begin
    if (clr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        mem_q[w][clr_idx_q] <= '0;
      end
    end else if (wr_en) begin
      mem_q[req_way][req_index] <= wr_line;
    end
  end

endmodule

// File: tb/tb_cache_data_array_bank.sv
// Bench for cache_data_array_bank: directed scenarios plus random
// traffic checked every cycle against a line-level reference model.
module tb_cache_data_array_bank;

  localparam int WAYS  = 2;
  localparam int DEPTH = 64;
  localparam int DW    = 128;
  localparam int NB    = DW / 8;

  logic          CK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [0:0]    req_way;
  logic [5:0]    req_index;
  logic [NB-1:0] req_wstrb;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          clear_req;
  logic          clear_busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mm [WAYS][DEPTH];
  int            busy_left;
  logic          exp_valid;
  logic [DW-1:0] exp_rdata;

  cache_data_array_bank #(
    .WAYS(WAYS), .DEPTH(DEPTH), .DATA_W(DW)
  ) dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_way(req_way),
    .req_index(req_index), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .clear_req(clear_req),
    .clear_busy(clear_busy)
  );

  always #5 CK = ~CK;

  task automatic chk(string tag, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < DEPTH; i++) mm[w][i] = '0;
  endtask

  // Effect of the coming edge, from the current inputs
  task automatic model_step();
    logic ready;
    logic a;
    ready = (busy_left == 0);
    if (RST) begin
      busy_left = DEPTH;
      zero_model();
      exp_valid = 1'b0;
      exp_rdata = '0;
      return;
    end
    a = req_valid && ready;
    exp_valid = a && !req_write;
    if (a && !req_write) exp_rdata = mm[req_way][req_index];
    if (a && req_write)
      for (int i = 0; i < NB; i++)
        if (req_wstrb[i])
          mm[req_way][req_index][8*i +: 8] = req_wdata[8*i +: 8];
    if (busy_left > 0) busy_left--;
    else if (clear_req) begin
      busy_left = DEPTH;
      zero_model();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CK);
    #1;
    chk("busy", DW'(clear_busy), DW'(busy_left != 0));
    chk("ready", DW'(req_ready), DW'(busy_left == 0));
    chk("valid", DW'(rsp_valid), DW'(exp_valid));
    chk("rdata", rsp_rdata, exp_rdata);
  endtask

  task automatic req(logic wr, logic [0:0] way, logic [5:0] idx,
                     logic [NB-1:0] strb, logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_way   = way;
    req_index = idx;
    req_wstrb = strb;
    req_wdata = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wstrb = '0;
    req_wdata = '0;
  endtask

  task automatic busy_len(string tag);
    int n;
    n = 0;
    while (clear_busy && n < 200) begin
      n++;
      tick();
    end
    chk(tag, DW'(n), DW'(DEPTH));
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] pat;
    logic [DW-1:0] a_d;
    logic [DW-1:0] b_d;
    logic [DW-1:0] held;
    zero_model();
    busy_left = 0;
    exp_valid = 1'b0;
    exp_rdata = '0;
    RST = 1'b1;
    clear_req = 1'b0;
    req_way = '0;
    req_index = '0;
    idle();

    // T1: reset, full sweep, then read the last line of way1
    tick();
    chk("t1_rst_valid", DW'(rsp_valid), '0);
    chk("t1_rst_rdata", rsp_rdata, '0);
    chk("t1_rst_busy", DW'(clear_busy), DW'(1));
    RST = 1'b0;
    busy_len("t1_busy_len");
    req(1'b0, 1'b1, 6'd63, '0, '0);
    tick();
    idle();
    chk("t1_rd63_valid", DW'(rsp_valid), DW'(1));
    chk("t1_rd63_data", rsp_rdata, '0);
    tick();
    chk("t1_valid_pulse", DW'(rsp_valid), '0);

    // T2: write then read same line, then other way
    pat = 128'h0123456789ABCDEF0123456789ABCDEF;
    req(1'b1, 1'b1, 6'd5, 16'hFFFF, pat);
    tick();
    chk("t2_wr_novalid", DW'(rsp_valid), '0);
    req(1'b0, 1'b1, 6'd5, '0, '0);
    tick();
    chk("t2_rd_data", rsp_rdata, pat);
    req(1'b0, 1'b0, 6'd5, '0, '0);
    tick();
    chk("t2_way_iso", rsp_rdata, '0);

    // T3: partial strobe clears the low four bytes only
    req(1'b1, 1'b0, 6'd7, 16'hFFFF, '1);
    tick();
    req(1'b1, 1'b0, 6'd7, 16'h000F, '0);
    tick();
    req(1'b1, 1'b0, 6'd7, 16'h0000, '0);
    tick();
    req(1'b0, 1'b0, 6'd7, '0, '0);
    tick();
    chk("t3_mask", rsp_rdata, {{96{1'b1}}, 32'h0});

    // T4: back-to-back W R W R on one line
    a_d = rnd128();
    b_d = rnd128();
    req(1'b1, 1'b0, 6'd0, 16'hFFFF, a_d);
    tick();
    req(1'b0, 1'b0, 6'd0, '0, '0);
    tick();
    chk("t4_rd_a", rsp_rdata, a_d);
    req(1'b1, 1'b0, 6'd0, 16'hFFFF, b_d);
    tick();
    chk("t4_w_novalid", DW'(rsp_valid), '0);
    req(1'b0, 1'b0, 6'd0, '0, '0);
    tick();
    chk("t4_rd_b", rsp_rdata, b_d);
    idle();
    repeat (3) tick();
    chk("t4_hold_b", rsp_rdata, b_d);

    // T5: fill lines, clear with a request held high
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 1'(i), 6'(i + 10), 16'hFFFF, rnd128());
      tick();
    end
    req(1'b0, 1'b1, 6'd11, '0, '0);
    tick();
    held = rsp_rdata;
    req(1'b0, 1'b0, 6'd10, '0, '0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    held = rsp_rdata;
    busy_len("t5_busy_len");
    chk("t5_hold", rsp_rdata, held);
    for (int i = 0; i < 6; i++) begin
      req(1'b0, 1'(i), 6'(i + 10), '0, '0);
      tick();
      chk("t5_zero", rsp_rdata, '0);
    end
    idle();

    // T6: reset in the middle of a sweep restarts it
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (30) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    busy_len("t6_busy_len");

    // Random traffic with occasional clears
    for (int c = 0; c < 600; c++) begin
      req($urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)),
          6'($urandom_range(0, 7)), 16'($urandom),
          rnd128());
      req_valid = $urandom_range(0, 3) != 0;
      clear_req = $urandom_range(0, 99) < 2;
      tick();
    end
    clear_req = 1'b0;
    idle();
    repeat (70) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
